// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin req/ack arbiter sharing one LIFO stack between two clients.
// Ports: clk, reset (async, active-low); per-client req/op/wdata -> ack/err/rdata;
//        stack side st_push/st_pop/st_wdata -> st_rdata/st_full/st_empty.
//        Define STACK_ARB_ERRCNT_EN to add err_cnt[7:0], a saturating reject count.
module stack_arbiter #(
  parameter int B = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         op0,
  input  logic [B-1:0] wdata0,
  output logic         ack0,
  output logic         err0,
  output logic [B-1:0] rdata0,
  input  logic         req1,
  input  logic         op1,
  input  logic [B-1:0] wdata1,
  output logic         ack1,
  output logic         err1,
  output logic [B-1:0] rdata1,
  output logic         st_push,
  output logic         st_pop,
  output logic [B-1:0] st_wdata,
  input  logic [B-1:0] st_rdata,
  input  logic         st_full,
  input  logic         st_empty
`ifdef STACK_ARB_ERRCNT_EN
  ,
  output logic [7:0]   err_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  logic [1:0]   state;
  logic         prio;
  logic         gid;
  logic         gop;
  logic         err_l;
  logic [B-1:0] gdata;
  logic         pick;
  logic         in_idle;
  logic         in_serve;
  logic         in_ack;

  assign in_idle  = (state == IDLE);
  assign in_serve = (state == SERVE);
  assign in_ack   = (state == ACK);

  // Contention goes to the pointer; otherwise the lone requester wins.
  assign pick = (req0 & req1) ? prio : req1;

  // Strobes follow the live flags so a full/empty change is honoured.
  assign st_push  = in_serve & ~gop & ~st_full;
  assign st_pop   = in_serve & gop & ~st_empty;
  assign st_wdata = gdata;

  assign ack0 = in_ack & ~gid;
  assign ack1 = in_ack & gid;
  assign err0 = ack0 & err_l;
  assign err1 = ack1 & err_l;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      prio   <= 1'b0;
      gid    <= 1'b0;
      gop    <= 1'b0;
      gdata  <= '0;
      err_l  <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      unique case (1'b1)
        in_idle: begin
          if (req0 | req1) begin
            gid   <= pick;
            gop   <= pick ? op1 : op0;
            gdata <= pick ? wdata1 : wdata0;
            state <= SERVE;
          end
        end
        in_serve: begin
          err_l <= gop ? st_empty : st_full;
          if (st_pop) begin
            if (gid) rdata1 <= st_rdata;
            else     rdata0 <= st_rdata;
          end
          state <= ACK;
        end
        in_ack: begin
          prio  <= ~gid;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STACK_ARB_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= 8'd0;
    end else if (in_ack && err_l && err_cnt != 8'hff) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed bench for stack_arbiter with a 4-deep stack model.
// Define STACK_ARB_ERRCNT_EN to also exercise err_cnt.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, op0, req1, op1;
  logic [2:0] wdata0, wdata1;
  logic       ack0, err0, ack1, err1;
  logic [2:0] rdata0, rdata1;
  logic       st_push, st_pop;
  logic [2:0] st_wdata, st_rdata;
  logic       st_full, st_empty;
`ifdef STACK_ARB_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_arbiter #(.B(3)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .op1(op1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .st_push(st_push), .st_pop(st_pop), .st_wdata(st_wdata),
    .st_rdata(st_rdata), .st_full(st_full), .st_empty(st_empty)
`ifdef STACK_ARB_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  logic [2:0] mem [4];
  logic [2:0] sp = 3'd0;

  assign st_full  = (sp == 3'd4);
  assign st_empty = (sp == 3'd0);
  assign st_rdata = (sp != 3'd0) ? mem[2'(sp - 3'd1)] : 3'd0;

  always @(posedge clk) begin
    if (st_push && !st_full) begin
      mem[sp[1:0]] <= st_wdata;
      sp <= sp + 3'd1;
    end else if (st_pop && !st_empty) begin
      sp <= sp - 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) chk("strobe_excl", st_push & st_pop, 1'b0);
  end

  // Starts just after a rising edge with the arbiter idle.
  task automatic run_op(input bit r, input bit op, input logic [2:0] d,
                        input bit xe, input logic [2:0] xr,
                        input string tag);
    if (r) begin req1 = 1; op1 = op; wdata1 = d; end
    else   begin req0 = 1; op0 = op; wdata0 = d; end
    @(negedge clk);
    chk({tag, ".idle_push"}, st_push, 1'b0);
    @(negedge clk);
    chk({tag, ".push"}, st_push, !xe && !op);
    chk({tag, ".pop"}, st_pop, !xe && op);
    if (!xe && !op) chk({tag, ".wdata"}, st_wdata, d);
    @(negedge clk);
    chk({tag, ".ack"}, r ? ack1 : ack0, 1'b1);
    chk({tag, ".ack_other"}, r ? ack0 : ack1, 1'b0);
    chk({tag, ".err"}, r ? err1 : err0, xe);
    chk({tag, ".rdata"}, r ? rdata1 : rdata0, xr);
    chk({tag, ".ack_strobe"}, st_push | st_pop, 1'b0);
    if (r) req1 = 0;
    else   req0 = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 0;
    req0 = 0; op0 = 0; wdata0 = 0;
    req1 = 0; op1 = 0; wdata1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ack0", ack0, 0);
    chk("rst.ack1", ack1, 0);
    chk("rst.err", err0 | err1, 0);
    chk("rst.strobes", st_push | st_pop, 0);
    chk("rst.rdata0", rdata0, 0);
    chk("rst.rdata1", rdata1, 0);
    chk("rst.st_wdata", st_wdata, 0);
`ifdef STACK_ARB_ERRCNT_EN
    chk("rst.err_cnt", err_cnt, 0);
`endif
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;

    run_op(0, 0, 3'b101, 0, 3'b000, "push0");
    run_op(1, 1, 3'b000, 0, 3'b101, "pop1");
    run_op(1, 1, 3'b000, 1, 3'b101, "pop1_empty");

    req0 = 1; op0 = 0; wdata0 = 3'b001;
    req1 = 1; op1 = 0; wdata1 = 3'b010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr.idle_push", st_push, 0);
      @(negedge clk);
      chk("rr.push", st_push, (k < 4));
      if (k < 4) chk("rr.wdata", st_wdata, (k % 2) ? 3'b010 : 3'b001);
      @(negedge clk);
      chk("rr.ack0", ack0, (k % 2 == 0));
      chk("rr.ack1", ack1, (k % 2 == 1));
      chk("rr.err", err0 | err1, (k == 4));
      if (k == 4) begin req0 = 0; req1 = 0; end
    end
    @(posedge clk); #1;

    run_op(0, 1, 3'b000, 0, 3'b010, "pop_before_rst");

    req0 = 1; op0 = 0; wdata0 = 3'b111;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid.push_before", st_push, 1);
    #1 reset = 0;
    #1;
    chk("rst_mid.push", st_push, 0);
    chk("rst_mid.pop", st_pop, 0);
    chk("rst_mid.st_wdata", st_wdata, 0);
    chk("rst_mid.rdata0", rdata0, 0);
    req0 = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid.no_ack0", ack0, 0);
    chk("rst_mid.no_ack1", ack1, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;

    req0 = 1; op0 = 0; wdata0 = 3'b100;
    req1 = 1; op1 = 0; wdata1 = 3'b011;
    @(negedge clk);
    @(negedge clk);
    chk("prio.push", st_push, 1);
    chk("prio.wdata", st_wdata, 3'b100);
    @(negedge clk);
    chk("prio.ack0", ack0, 1);
    chk("prio.ack1", ack1, 0);
    req0 = 0; req1 = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle.strobes", st_push | st_pop, 0);
      chk("idle.acks", ack0 | ack1, 0);
    end
    @(posedge clk); #1;

    run_op(1, 1, 3'b000, 0, 3'b100, "drain1");
    run_op(0, 1, 3'b000, 0, 3'b001, "drain2");
    run_op(1, 1, 3'b000, 0, 3'b010, "drain3");
    run_op(0, 1, 3'b000, 0, 3'b001, "drain4");
    for (int i = 0; i < 3; i++) run_op(0, 1, 3'b000, 1, 3'b001, "emptypop");
`ifdef STACK_ARB_ERRCNT_EN
    chk("errcnt.three", err_cnt, 8'd3);
    for (int i = 0; i < 257; i++) run_op(0, 1, 3'b000, 1, 3'b001, "sat");
    chk("errcnt.sat", err_cnt, 8'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one B-bit LIFO stack (push/pop/w_data/r_data/full/empty interface) between two independent requesters.
- Round-robin arbitration with a per-request req/ack handshake.
- Issues single-cycle push/pop strobes to the stack and returns pop data and an error flag to the winner.
- Sits between the stack instance and the two client circuits (e.g. debounced button logic, or a second FSM).

Parameters:
- B, 3, data width of the stack word and all data ports.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 request; held high until ack0 is sampled
- op0  input  1  requester 0 operation: 0 = push, 1 = pop
- wdata0  input  B  requester 0 push data
- ack0  output  1  one-cycle completion pulse to requester 0
- err0  output  1  valid with ack0: 1 = rejected (push when full / pop when empty)
- rdata0  output  B  pop result for requester 0; held until the next ack0
- req1, op1, wdata1, ack1, err1, rdata1  same as the requester 0 set, for requester 1
- st_push  output  1  push strobe to stack
- st_pop  output  1  pop strobe to stack
- st_wdata  output  B  push data to stack
- st_rdata  input  B  stack top-of-stack, combinational
- st_full  input  1  stack full flag
- st_empty  input  1  stack empty flag

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - Priority pointer = requester 0.
  - ack*, err*, st_push, st_pop = 0; rdata* = 0; st_wdata = 0.
- Registered state: FSM with states IDLE, SERVE, ACK. All outputs are registered or decoded from registered state.
- IDLE:
  - If no req, stay.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester named by the priority pointer.
  - On grant: latch grant id, op and wdata; go to SERVE.
- SERVE (one cycle), judged on st_full/st_empty in this cycle:
  - push and not st_full: st_push=1, st_wdata=latched data.
  - pop and not st_empty: st_pop=1; st_rdata is captured into the grantee's rdata register at the end of the cycle.
  - push when st_full, or pop when st_empty: no strobe; the error bit is latched.
  - Always go to ACK.
- ACK (one cycle):
  - ack of the grantee = 1 and err of the grantee = latched error. The other requester's ack/err stay 0.
  - Priority pointer moves to the non-granted requester.
  - Return to IDLE.
- Strobes: st_push and st_pop are never high together and never high outside SERVE; exactly one strobe per successful operation.
- Latency: req sampled high in IDLE at edge n → strobe in cycle n+1 → ack in cycle n+2. Throughput is 1 operation per 3 cycles.
- Handshake:
  - The requester holds req/op/wdata stable until it samples ack=1, then drops req at that same edge.
  - A req still high in the IDLE cycle after an ack is treated as a new request.
  - op/wdata changes while req is high but not granted are legal; the latched values come from the grant edge.
- Failed pop: rdata is left unchanged.
- Push errors: err is asserted and the stack is not touched.
- Simultaneous requests are alternated strictly: A, B, A, B while both are held.
- Reset mid-operation aborts any pending ack. A strobe already clocked into the stack is not undone.

Optional Feature:
- Macro: STACK_ARB_ERRCNT_EN.
- Defined:
  - Adds output err_cnt [7:0], an 8-bit saturating count of rejected operations from both requesters.
  - Increments in the ACK cycle when err=1 and holds at 255.
  - Cleared by reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then req0 push 3'b101 with the stack empty → st_push=1 with st_wdata=101 exactly 1 cycle after the grant edge; ack0=1, err0=0 the next cycle; ack1 stays 0.
- Continuing from the previous case, req1 pop → st_pop=1; ack1=1, err1=0, rdata1=101. Then req1 pop again on the empty stack → err1=1, no st_pop, rdata1 still 101.
- Both req0 and req1 held high continuously, each pushing (0 pushes 001, 1 pushes 010), with B=3 and a 4-deep stack → grant order 0,1,0,1; the 5th request (requester 0) gets ack0 with err0=1 and no st_push.
- Assert reset in SERVE cycle of a push → all outputs 0 immediately, no ack issued, FSM in IDLE, and requester 0 has priority after release.
- With STACK_ARB_ERRCNT_EN, 3 pops on an empty stack → err_cnt=3. Force 260 errors → err_cnt=255.
- Requester drops req at the ack edge → no second operation issued; an idle bus shows st_push=st_pop=0 for 10 cycles.
